// File: rtl/gcd_controller.sv
// gcd_controller
// ----------------------------------------------------------------------------
// FSM controller for a 16-bit subtract-and-compare GCD datapath. It loads
// operand A and then operand B from the shared data_in bus. It then steps the
// subtraction loop until the datapath reports equality. A watchdog ends a
// non-terminating run, which happens when one operand is zero.
//
// Optional feature (macro GCD_ABORT_EN):
//   When defined, adds an 'abort' input. If abort is high at a clock edge in
//   LOAD_A, LOAD_B or CALC, the controller returns to IDLE. No done pulse is
//   produced, err is left unchanged and iter_count holds its value.
//
// Parameters:
//   MAX_ITER   subtraction steps allowed before the watchdog fires
//   ITER_W     iteration counter width (2**ITER_W-1 >= MAX_ITER)
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           run request, sampled only in IDLE
//   abort           (GCD_ABORT_EN only) cancel the current run
//   gt, lt, eq      datapath compare flags (A>B, A<B, A==B)
//   lda, ldb        load strobes for datapath registers A and B
//   sel1, sel2      subtractor minuend/subtrahend select (0=A, 1=B)
//   sel_in          register input select (1=data_in, 0=subtractor)
//   req_a, req_b    upstream must drive operand A / B on data_in this cycle
//   ready           controller is idle and will accept start
//   done            one-cycle completion pulse (also fires on watchdog error)
//   err             watchdog expired; sticky until the next accepted start
//   iter_count      subtraction steps of the last/current run
// ----------------------------------------------------------------------------
module gcd_controller #(
  parameter int MAX_ITER = 65535,
  parameter int ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef GCD_ABORT_EN
  input  logic              abort,
`endif
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              lda,
  output logic              ldb,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              req_a,
  output logic              req_b,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE,
    ERROR
  } state_t;

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  state_t state;
  state_t next_state;
  logic   run_accept;
  logic   iter_inc;
  logic   err_set;

  // State register plus the iteration counter and sticky error flag.
  // Both are cleared only when a new run is accepted, so they keep the
  // previous run's results while the controller sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter_count <= '0;
      err        <= 1'b0;
    end else begin
      state <= next_state;
      if (run_accept) begin
        iter_count <= '0;
        err        <= 1'b0;
      end else if (iter_inc) begin
        iter_count <= iter_count + ITER_W'(1);
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode. In CALC the strobes are Mealy on the
  // compare flags. Equality wins over the watchdog, so a run that reaches
  // equality on exactly the MAX_ITER-th step still completes cleanly. An
  // all-zero flag set is treated as equality, so corrupt flags cannot spin
  // the loop.
  always_comb begin
    next_state = state;
    lda        = 1'b0;
    ldb        = 1'b0;
    sel1       = 1'b0;
    sel2       = 1'b0;
    sel_in     = 1'b0;
    req_a      = 1'b0;
    req_b      = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    run_accept = 1'b0;
    iter_inc   = 1'b0;
    err_set    = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          next_state = LOAD_A;
          run_accept = 1'b1;
        end
      end
      LOAD_A: begin
        sel_in     = 1'b1;
        lda        = 1'b1;
        req_a      = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        sel_in     = 1'b1;
        ldb        = 1'b1;
        req_b      = 1'b1;
        next_state = CALC;
      end
      CALC: begin
        if (eq || !(gt || lt)) begin
          next_state = DONE;
        end else if (iter_count == MAX_CNT) begin
          next_state = ERROR;
          err_set    = 1'b1;
        end else if (gt) begin
          sel2     = 1'b1;
          lda      = 1'b1;
          iter_inc = 1'b1;
        end else begin
          sel1     = 1'b1;
          ldb      = 1'b1;
          iter_inc = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      ERROR: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

`ifdef GCD_ABORT_EN
    // An abort during an active run drops every strobe. This prevents a
    // half-finished step from disturbing the datapath or the counter.
    if (abort && (state == LOAD_A || state == LOAD_B || state == CALC)) begin
      next_state = IDLE;
      lda        = 1'b0;
      ldb        = 1'b0;
      sel1       = 1'b0;
      sel2       = 1'b0;
      sel_in     = 1'b0;
      req_a      = 1'b0;
      req_b      = 1'b0;
      iter_inc   = 1'b0;
      err_set    = 1'b0;
    end
`endif
  end

endmodule
